ascon_perm_core: RTL and testbench
==================================

# ascon_perm_core

Iterative ASCON permutation engine sitting directly downstream of the ASCON register file. It samples the 320-bit state and start flag that software programs there, then applies a programmable number of rounds (p^a / p^b). It returns the permuted state with a one-cycle write-back strobe and a completion pulse that the register file uses to update its state and status fields.

## Interface
- ROUNDS_PER_CYCLE, default 1: rounds evaluated per clock. Legal values are 1 or 2; any other value is an elaboration error.
- clk_i  input  1  system clock, rising-edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  start level from the status register. A 0→1 transition launches a permutation.
- rounds_i  input  4  round count n. Legal range 1..12. Values 0 and 13..15 are treated as 12.
- state_i  input  [4:0][63:0]  input state; word k is x_k.
- state_o  output  [4:0][63:0]  internal state register, always visible.
- update_state_o  output  1  one-cycle write-back strobe for state_o.
- finished_o  output  1  one-cycle completion pulse, coincident with update_state_o.
- busy_o  output  1  high from the load cycle through the DONE cycle.

## Operation
- FSM states: IDLE, ROUND, DONE.
- **start_q:** a registered copy of start_i. An edge is defined as start_i & ~start_q.
- **IDLE:**
  - On an edge, latch state_i into the state register.
  - Latch r = 12 − n′, where n′ is the sanitised rounds_i.
  - Go to ROUND.
  - If there is no edge, hold state.
- **ROUND:** each cycle applies min(ROUNDS_PER_CYCLE, 12 − r) rounds and advances r by that amount. When r reaches 12, go to DONE. With ROUNDS_PER_CYCLE=2 and odd n, the final cycle applies exactly one round; the second round is bypassed by a mux.
- **DONE:** assert update_state_o and finished_o for one cycle, then return to IDLE.
- **Round function** (round index r), in this order:
  1. Constant addition: x2 ^= {56'b0, (4'hF − r[3:0]), r[3:0]}.
  2. Bitsliced 5-bit S-box, using the ASCON reference χ-based sequence.
  3. Linear layer: x_k ^= ror(x_k, a_k) ^ ror(x_k, b_k), with (a,b) = (19,28), (61,39), (1,6), (10,17), (7,41) for x0..x4.
- **Edges outside IDLE:** an edge arriving in ROUND or DONE is ignored. It is not queued. start_q still tracks start_i, so a level held high never relaunches the permutation.
- **rounds_i and state_i sampling:** both are sampled only on the launch cycle. Later changes have no effect on an operation in flight.

## Timing
- **Reset values** (asserting rst_i forces all of these asynchronously):
  - state register and state_o: 0.
  - update_state_o, finished_o, busy_o: 0.
  - start_q: 0.
  - FSM: IDLE.
- **Reset mid-operation:** aborts immediately. No finished_o pulse is produced for the aborted operation.
- **Launch edge at cycle T:**
  - The state is loaded at the T clock edge.
  - busy_o is high in cycles T+1 .. T+L+1, where L = ceil(n′ / ROUNDS_PER_CYCLE).
  - The DONE pulse occurs in cycle T+L+1, and state_o then holds the final result.
- **Latency examples:**
  - ROUNDS_PER_CYCLE=1, n=12: pulse at T+13.
  - ROUNDS_PER_CYCLE=2, n=6: pulse at T+4.
- **Back-to-back:** the earliest relaunch is an edge seen in the first IDLE cycle, i.e. the cycle after DONE.
- **Combinational paths:** there are none from inputs to outputs. All outputs are register-driven.

## Configuration
- Macro ASCON_PERM_CNT_EN.
- When defined, the block adds output perm_count_o [31:0]:
  - Reset value 0.
  - Increments by 1 on every finished_o.
  - Wraps from 0xFFFF_FFFF to 0.
  - Aborted operations are not counted.
- When undefined, the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- **Shared package ascon_pkg:**
  - ascon_state_t (logic [4:0][63:0]).
  - ROUNDS_MAX = 12.
  - Rotation-amount constants.
  - Round-constant function rc(r).
- **Sub-module ascon_round:** purely combinational. It takes state plus a 4-bit round index and returns the next state. It is instantiated ROUNDS_PER_CYCLE times in the core.
- **Core contents:** FSM, round counter, start edge detector, state register, optional counter.

## Test plan
- **Single round on zero state.** Zero state_i, rounds_i=1, edge at T → finished_o at T+2 with:
  - x1 = 0x0000_0000_9600_0213
  - x3 = 0x12E5_8000_0000_004B
  - x4 = 0
- **Full p^a against golden model.** rounds_i=12, ROUNDS_PER_CYCLE=1 → pulse exactly at T+13, and state_o matches the C reference model for 100 random states.
- **Odd count at two rounds per cycle.** ROUNDS_PER_CYCLE=2, rounds_i=7 → pulse at T+5. Result is identical to ROUNDS_PER_CYCLE=1 with rounds_i=7.
- **Held start and mid-run edges.** Keep start_i high after finishing → no second launch. Toggle start_i 1→0→1 during ROUND → ignored, with exactly one finished_o pulse.
- **Reset mid-operation.** Assert rst_i at T+5 of a 12-round run → state_o=0, busy_o=0, no pulse. A fresh launch after release works normally.
- **Counter and illegal count.** With ASCON_PERM_CNT_EN:
  - Three runs → perm_count_o=3.
  - rounds_i=0 behaves as 12 rounds.

Source files
------------

// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared ASCON types, constants and helper functions
// Contents: ascon_state_t (x0..x4), ascon_fsm_t, ROUNDS_MAX, linear-layer
// rotation amounts, rc() round constant, ror64() and sanitize_rounds().
package ascon_pkg;

  typedef logic [4:0][63:0] ascon_state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } ascon_fsm_t;

  localparam int ROUNDS_MAX = 12;

  // Linear-layer rotation pairs (a_k, b_k) for x0..x4
  localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] rc(input logic [3:0] r);
    return {56'b0, 4'hF - r, r};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // 0 and 13..15 run the full 12 rounds
  function automatic logic [3:0] sanitize_rounds(input logic [3:0] n);
    return ((n == 4'd0) || (n > 4'(ROUNDS_MAX))) ? 4'(ROUNDS_MAX) : n;
  endfunction

endpackage

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational ASCON round (constant, S-box, linear layer)
// Ports: state (in, 320b), round_idx (in, 4b), next_state (out, 320b).
import ascon_pkg::*;

module ascon_round (
  input  ascon_state_t state,
  input  logic [3:0]   round_idx,
  output ascon_state_t next_state
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;
  ascon_state_t sb;

  always_comb begin
    x0 = state[0];
    x1 = state[1];
    x2 = state[2] ^ rc(round_idx);
    x3 = state[3];
    x4 = state[4];

    // Bitsliced S-box, reference chi-based sequence
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    sb = {x4, x3, x2, x1, x0};
    next_state = sb;
    for (int k = 0; k < 5; k++) begin
      next_state[k] = sb[k] ^ ror64(sb[k], ROT_A[k]) ^ ror64(sb[k], ROT_B[k]);
    end
  end

endmodule

// File: rtl/ascon_perm_core.sv
// rtl/ascon_perm_core.sv - iterative ASCON permutation engine, 1 or 2 rounds per clock
// Ports: clk_i, rst_i (async, active-high), start_i (level; rising edge launches),
// rounds_i (round count), state_i (input state), state_o (state register),
// update_state_o / finished_o (one-cycle completion strobes), busy_o.
// Optional macro ASCON_PERM_CNT_EN adds perm_count_o, a wrapping completion counter.
import ascon_pkg::*;

module ascon_perm_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [3:0]   rounds_i,
  input  ascon_state_t state_i,
  output ascon_state_t state_o,
  output logic         update_state_o,
  output logic         finished_o,
  output logic         busy_o
`ifdef ASCON_PERM_CNT_EN
  ,
  output logic [31:0]  perm_count_o
`endif
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_bad_rpc
    $error("ascon_perm_core: ROUNDS_PER_CYCLE must be 1 or 2");
  end

  ascon_fsm_t   fsm_q, fsm_d;
  ascon_state_t state_q, state_d;
  ascon_state_t round1_out, round2_out;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   rem;
  logic         start_q;
  logic         launch;

  assign launch = start_i & ~start_q;
  assign rem    = 4'(ROUNDS_MAX) - rnd_q;

  ascon_round u_round0 (
    .state      (state_q),
    .round_idx  (rnd_q),
    .next_state (round1_out)
  );

  if (ROUNDS_PER_CYCLE == 2) begin : g_two
    ascon_round u_round1 (
      .state      (round1_out),
      .round_idx  (rnd_q + 4'd1),
      .next_state (round2_out)
    );
  end else begin : g_one
    assign round2_out = round1_out;
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    case (fsm_q)
      S_IDLE: begin
        if (launch) begin
          state_d = state_i;
          rnd_d   = 4'(ROUNDS_MAX) - sanitize_rounds(rounds_i);
          fsm_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        // Only one round left at two rounds per cycle: bypass the second stage
        if (ROUNDS_PER_CYCLE == 1 || rem == 4'd1) begin
          state_d = round1_out;
          rnd_d   = rnd_q + 4'd1;
        end else begin
          state_d = round2_out;
          rnd_d   = rnd_q + 4'd2;
        end
        if (rnd_d == 4'(ROUNDS_MAX)) fsm_d = S_DONE;
      end
      S_DONE:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      start_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      start_q <= start_i;
    end
  end

  assign state_o        = state_q;
  assign busy_o         = (fsm_q != S_IDLE);
  assign finished_o     = (fsm_q == S_DONE);
  assign update_state_o = (fsm_q == S_DONE);

`ifdef ASCON_PERM_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) perm_count_o <= '0;
    else if (fsm_q == S_DONE) perm_count_o <= perm_count_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ascon_perm_core.sv
// tb/tb_ascon_perm_core.sv - scoreboard bench for ascon_perm_core at 1 and 2 rounds per cycle
module tb_ascon_perm_core;

  typedef logic [4:0][63:0] st_t;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  rounds;
  st_t         st_in;
  st_t         st_o1, st_o2;
  logic        upd1, upd2, fin1, fin2, busy1, busy2;
`ifdef ASCON_PERM_CNT_EN
  logic [31:0] cnt1, cnt2;
`endif

  int  checks = 0;
  int  errors = 0;
  int  exp_cnt = 0;
  st_t q1[$];
  st_t q2[$];
  st_t res1, res2;

  always #5 clk = ~clk;

  ascon_perm_core #(.ROUNDS_PER_CYCLE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .rounds_i(rounds), .state_i(st_in),
    .state_o(st_o1), .update_state_o(upd1), .finished_o(fin1), .busy_o(busy1)
`ifdef ASCON_PERM_CNT_EN
    , .perm_count_o(cnt1)
`endif
  );

  ascon_perm_core #(.ROUNDS_PER_CYCLE(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .rounds_i(rounds), .state_i(st_in),
    .state_o(st_o2), .update_state_o(upd2), .finished_o(fin2), .busy_o(busy2)
`ifdef ASCON_PERM_CNT_EN
    , .perm_count_o(cnt2)
`endif
  );

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rot(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic int eff_rounds(input logic [3:0] n);
    return (n == 0 || n > 12) ? 12 : int'(n);
  endfunction

  function automatic st_t model(input st_t s_in, input logic [3:0] n);
    st_t        s;
    logic [4:0] v, o;
    s = s_in;
    for (int r = 12 - eff_rounds(n); r < 12; r++) begin
      s[2] = s[2] ^ 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        v = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
        o = SBOX[v];
        {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]} = o;
      end
      s[0] = s[0] ^ rot(s[0], 19) ^ rot(s[0], 28);
      s[1] = s[1] ^ rot(s[1], 61) ^ rot(s[1], 39);
      s[2] = s[2] ^ rot(s[2], 1)  ^ rot(s[2], 6);
      s[3] = s[3] ^ rot(s[3], 10) ^ rot(s[3], 17);
      s[4] = s[4] ^ rot(s[4], 7)  ^ rot(s[4], 41);
    end
    return s;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
    return s;
  endfunction

  // Launch one permutation and watch both engines for 16 cycles
  task automatic run_op(input logic [3:0] n, input st_t s, input bit hold, input bit toggle);
    int l1, l2, p1, p2;
    l1 = eff_rounds(n);
    l2 = (l1 + 1) / 2;
    p1 = 0;
    p2 = 0;
    start = 1'b0;
    @(negedge clk);
    rounds = n;
    st_in  = s;
    start  = 1'b1;
    q1.push_back(model(s, n));
    q2.push_back(model(s, n));
    exp_cnt++;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) begin
        rounds = 4'($urandom);
        st_in  = rand_state();
      end
      if (toggle && k == 2) start = 1'b0;
      if (toggle && k == 3) start = 1'b1;
      chk("upd1_eq_fin1", upd1, fin1);
      chk("upd2_eq_fin2", upd2, fin2);
      if (fin1) begin
        p1++;
        chk("latency1", k, l1 + 1);
        if (q1.size() > 0) begin
          res1 = st_o1;
          chk("result1", st_o1, q1.pop_front());
        end
      end
      if (fin2) begin
        p2++;
        chk("latency2", k, l2 + 1);
        if (q2.size() > 0) begin
          res2 = st_o2;
          chk("result2", st_o2, q2.pop_front());
        end
      end
    end
    chk("pulses1", p1, 1);
    chk("pulses2", p2, 1);
    if (!hold) start = 1'b0;
`ifdef ASCON_PERM_CNT_EN
    chk("count1", cnt1, exp_cnt);
    chk("count2", cnt2, exp_cnt);
`endif
  endtask

  initial begin
    int   any_act;
    st_t  zero;
    zero   = '0;
    rst    = 1'b1;
    start  = 1'b0;
    rounds = 4'd0;
    st_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst_state1", st_o1, 320'd0);
    chk("rst_state2", st_o2, 320'd0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_fin1", {fin1, upd1}, 2'b00);
    chk("rst_busy2", busy2, 1'b0);
    chk("rst_fin2", {fin2, upd2}, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    // Single round on zero state: known constants
    run_op(4'd1, zero, 1'b0, 1'b0);
    chk("zero_x1", res1[1], 64'h0000_0000_9600_0213);
    chk("zero_x3", res1[3], 64'h12E5_8000_0000_004B);
    chk("zero_x4", res1[4], 64'h0);
    chk("zero_x3_rpc2", res2[3], 64'h12E5_8000_0000_004B);

    // Full p^a on random states
    for (int i = 0; i < 100; i++) run_op(4'd12, rand_state(), 1'b0, 1'b0);

    // Odd and even counts, bypass path at two rounds per cycle
    run_op(4'd7, rand_state(), 1'b0, 1'b0);
    run_op(4'd6, rand_state(), 1'b0, 1'b0);
    run_op(4'd3, rand_state(), 1'b0, 1'b0);

    // Held start level never relaunches
    run_op(4'd5, rand_state(), 1'b1, 1'b0);
    any_act = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy1 || busy2 || fin1 || fin2) any_act++;
    end
    chk("held_no_relaunch", any_act, 0);

    // Start toggled during ROUND is ignored
    run_op(4'd12, rand_state(), 1'b0, 1'b1);

    // Reset mid-operation
    start = 1'b0;
    @(negedge clk);
    rounds = 4'd12;
    st_in  = rand_state();
    start  = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_cnt = 0;
    chk("abort_state1", st_o1, 320'd0);
    chk("abort_busy1", busy1, 1'b0);
    chk("abort_state2", st_o2, 320'd0);
    chk("abort_busy2", busy2, 1'b0);
    start = 1'b0;
    any_act = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (fin1 || fin2 || upd1 || upd2) any_act++;
    end
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (fin1 || fin2 || busy1 || busy2) any_act++;
    end
    chk("abort_no_pulse", any_act, 0);

    // Fresh launches after reset, including sanitised counts
    run_op(4'd12, rand_state(), 1'b0, 1'b0);
    run_op(4'd0,  rand_state(), 1'b0, 1'b0);
    run_op(4'd13, rand_state(), 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
